// File: rtl/run_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : run_ctrl_pkg
//  Description : Shared types and constants for the run/halt/step sequencer:
//                sequencer state enum, debug command opcodes, fetch-state
//                default encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_HALTED     = 3'd0,
        ST_RUN        = 3'd1,
        ST_DRAIN      = 3'd2,
        ST_STEP_FIRST = 3'd3,
        ST_STEP_REST  = 3'd4
    } run_state_t;

    // Debug command opcodes carried on cmd_op
    localparam logic [1:0] CMD_HALT     = 2'b00;
    localparam logic [1:0] CMD_RUN      = 2'b01;
    localparam logic [1:0] CMD_STEP     = 2'b10;
    localparam logic [1:0] CMD_CLEAR_BP = 2'b11;

    // Controller fetch-state encoding of the multi-cycle CPU
    localparam logic [3:0] FETCH_STATE_DEFAULT = 4'd0;

endpackage
`default_nettype wire

// File: rtl/run_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : run_control_unit_if
//  Description : Debug command channel, CPU observation signals and status
//                outputs of the run control unit. The master side is the
//                computer/debugger, the slave side is the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface run_control_unit_if #(
    parameter int PC_WIDTH    = 32,
    parameter int STATE_WIDTH = 4,
    parameter int CNT_WIDTH   = 32
);
    logic                   cmd_valid;
    logic [1:0]             cmd_op;
    logic                   cmd_ready;
    logic                   bp_enable;
    logic [PC_WIDTH-1:0]    bp_addr;
    logic [PC_WIDTH-1:0]    fetchPC;
    logic [STATE_WIDTH-1:0] fsm_state;
    logic                   cpu_enable;
    logic                   halted;
    logic                   bp_hit;
    logic [CNT_WIDTH-1:0]   instr_count;
    logic [CNT_WIDTH-1:0]   cycle_count;

    modport master (
        output cmd_valid, cmd_op, bp_enable, bp_addr, fetchPC, fsm_state,
        input  cmd_ready, cpu_enable, halted, bp_hit, instr_count, cycle_count
    );

    modport slave (
        input  cmd_valid, cmd_op, bp_enable, bp_addr, fetchPC, fsm_state,
        output cmd_ready, cpu_enable, halted, bp_hit, instr_count, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/run_control_unit_event_counter.sv
`default_nettype none
// ============================================================================
//  Module      : event_counter
//  Description : Free-running wrap-around event counter, increments once per
//                cycle with i_en high, cleared only by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module event_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 i_en,
    output logic [CNT_WIDTH-1:0]      o_count
);
    logic [CNT_WIDTH-1:0] r_count;

    // Count enabled cycles, wrapping naturally at 2^CNT_WIDTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/run_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : run_control_unit
//  Description : Run/halt/single-step sequencer for the multi-cycle CPU.
//                Gates CPU progress through cpu_enable, pauses only at
//                instruction boundaries, offers a PC breakpoint and
//                retired-instruction / active-cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_control_unit
    import run_ctrl_pkg::*;
#(
    parameter int                     PC_WIDTH      = 32,
    parameter int                     STATE_WIDTH   = 4,
    parameter logic [STATE_WIDTH-1:0] FETCH_STATE   = STATE_WIDTH'(FETCH_STATE_DEFAULT),
    parameter int                     CNT_WIDTH     = 32,
    parameter bit                     START_RUNNING = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    run_control_unit_if.slave bus
);
    localparam run_state_t RESET_STATE = START_RUNNING ? ST_RUN : ST_HALTED;

    run_state_t r_state;
    run_state_t w_state_nxt;
    logic       r_bp_skip;
    logic       w_bp_skip_nxt;
    logic       r_bp_hit;
    logic       w_bp_hit_nxt;

    logic       w_at_fetch;
    logic       w_bp_match;
    logic       w_cmd_ready;
    logic       w_cmd_acc;
    logic       w_cpu_enable;

    assign w_at_fetch  = (bus.fsm_state == FETCH_STATE);
    // bp_skip lets the instruction sitting on the breakpoint run once after RUN
    assign w_bp_match  = bus.bp_enable && w_at_fetch && (bus.fetchPC == bus.bp_addr)
                         && !r_bp_skip && (r_state == ST_RUN);
    assign w_cmd_ready = (r_state == ST_HALTED) || (r_state == ST_RUN);
    assign w_cmd_acc   = bus.cmd_valid && w_cmd_ready;

    // CPU enable: zero-latency gate derived from the current state
    always_comb begin
        w_cpu_enable = 1'b0;
        unique case (r_state)
            ST_HALTED:     w_cpu_enable = 1'b0;
            ST_RUN:        w_cpu_enable = !w_bp_match;
            ST_DRAIN:      w_cpu_enable = !w_at_fetch;
            ST_STEP_FIRST: w_cpu_enable = 1'b1;
            ST_STEP_REST:  w_cpu_enable = !w_at_fetch;
            default:       w_cpu_enable = 1'b0;
        endcase
    end

    // Next-state, breakpoint-skip and sticky-hit logic
    always_comb begin
        w_state_nxt   = r_state;
        w_bp_skip_nxt = r_bp_skip;
        w_bp_hit_nxt  = r_bp_hit;
        unique case (r_state)
            ST_HALTED: begin
                if (w_cmd_acc) begin
                    unique case (bus.cmd_op)
                        CMD_RUN: begin
                            w_state_nxt   = ST_RUN;
                            w_bp_skip_nxt = 1'b1;
                            w_bp_hit_nxt  = 1'b0;
                        end
                        CMD_STEP: begin
                            w_state_nxt  = ST_STEP_FIRST;
                            w_bp_hit_nxt = 1'b0;
                        end
                        CMD_CLEAR_BP: w_bp_hit_nxt = 1'b0;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (w_cpu_enable && w_at_fetch) begin
                    w_bp_skip_nxt = 1'b0;
                end
                if (w_cmd_acc && bus.cmd_op == CMD_CLEAR_BP) begin
                    w_bp_hit_nxt = 1'b0;
                end
                // Breakpoint wins over a same-cycle HALT
                if (w_bp_match) begin
                    w_state_nxt  = ST_HALTED;
                    w_bp_hit_nxt = 1'b1;
                end else if (w_cmd_acc && bus.cmd_op == CMD_HALT) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_at_fetch) w_state_nxt = ST_HALTED;
            end
            ST_STEP_FIRST: w_state_nxt = ST_STEP_REST;
            ST_STEP_REST: begin
                if (w_at_fetch) w_state_nxt = ST_HALTED;
            end
            default: w_state_nxt = RESET_STATE;
        endcase
    end

    // State and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= RESET_STATE;
            r_bp_skip <= 1'b0;
            r_bp_hit  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bp_skip <= w_bp_skip_nxt;
            r_bp_hit  <= w_bp_hit_nxt;
        end
    end

    assign bus.cpu_enable = w_cpu_enable;
    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.halted     = (r_state == ST_HALTED);
    assign bus.bp_hit     = r_bp_hit;

    event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_cpu_enable),
        .o_count (bus.cycle_count)
    );

    event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instr_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_cpu_enable && w_at_fetch),
        .o_count (bus.instr_count)
    );
endmodule
`default_nettype wire

// File: tb/tb_run_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_control_unit
//  Description : Self-checking bench for run_control_unit with a toy
//                multi-cycle CPU (3..5 cycles per instruction) and a
//                behavioural reference model compared on every negedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_run_control_unit;
    localparam int CW   = 4;
    localparam int MASK = (1 << CW) - 1;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    run_control_unit_if #(.PC_WIDTH(32), .STATE_WIDTH(4), .CNT_WIDTH(CW)) bus ();

    run_control_unit #(
        .PC_WIDTH(32), .STATE_WIDTH(4), .FETCH_STATE(4'd0),
        .CNT_WIDTH(CW), .START_RUNNING(1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Toy CPU: instruction length depends on its PC; PC advances in fetch
    function automatic int ilen(input logic [31:0] pc);
        return 3 + int'(((pc >> 2) + 1) % 3);
    endfunction

    int cur_len;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.fetchPC   <= 32'h0;
            bus.fsm_state <= 4'd0;
            cur_len       <= 4;
        end else if (bus.cpu_enable) begin
            if (bus.fsm_state == 4'd0) begin
                bus.fetchPC   <= bus.fetchPC + 32'd4;
                cur_len       <= ilen(bus.fetchPC);
                bus.fsm_state <= 4'd1;
            end else if (int'(bus.fsm_state) + 1 == cur_len) begin
                bus.fsm_state <= 4'd0;
            end else begin
                bus.fsm_state <= bus.fsm_state + 4'd1;
            end
        end
    end

    // Reference model: described as modes (halted / running / draining /
    // stepping with a fetch pending or done) and plain event counts
    bit m_halted, m_draining, m_skip, m_hit;
    int m_step;          // 0 not stepping, 1 fetch pending, 2 finishing
    int m_icnt, m_ccnt;
    bit f_at, f_run, f_bpm, f_en, f_rdy, f_acc;

    always @(negedge clk) begin
        if (!reset) begin
            m_halted = 1; m_draining = 0; m_skip = 0; m_hit = 0;
            m_step = 0; m_icnt = 0; m_ccnt = 0;
            chk("rst_halted", 32'(bus.halted), 1);
            chk("rst_enable", 32'(bus.cpu_enable), 0);
            chk("rst_icnt", 32'(bus.instr_count), 0);
            chk("rst_ccnt", 32'(bus.cycle_count), 0);
        end else begin
            f_at  = (bus.fsm_state == 4'd0);
            f_run = !m_halted && !m_draining && (m_step == 0);
            f_bpm = f_run && bus.bp_enable && f_at && (bus.fetchPC == bus.bp_addr) && !m_skip;
            if (m_halted)         f_en = 0;
            else if (f_run)       f_en = !f_bpm;
            else if (m_step == 1) f_en = 1;
            else                  f_en = !f_at;
            f_rdy = m_halted || f_run;
            chk("cpu_enable", 32'(bus.cpu_enable), 32'(f_en));
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(f_rdy));
            chk("halted", 32'(bus.halted), 32'(m_halted));
            chk("bp_hit", 32'(bus.bp_hit), 32'(m_hit));
            chk("instr_count", 32'(bus.instr_count), 32'(m_icnt & MASK));
            chk("cycle_count", 32'(bus.cycle_count), 32'(m_ccnt & MASK));
            // advance model across the coming rising edge
            f_acc = bus.cmd_valid && f_rdy;
            if (f_en) m_ccnt++;
            if (f_en && f_at) m_icnt++;
            if (m_halted) begin
                if (f_acc && bus.cmd_op == 2'b01) begin m_halted = 0; m_skip = 1; m_hit = 0; end
                else if (f_acc && bus.cmd_op == 2'b10) begin m_halted = 0; m_step = 1; m_hit = 0; end
                else if (f_acc && bus.cmd_op == 2'b11) m_hit = 0;
            end else if (f_run) begin
                if (f_en && f_at) m_skip = 0;
                if (f_bpm) begin m_halted = 1; m_hit = 1; end
                else begin
                    if (f_acc && bus.cmd_op == 2'b00) m_draining = 1;
                    if (f_acc && bus.cmd_op == 2'b11) m_hit = 0;
                end
            end else if (m_draining) begin
                if (f_at) begin m_draining = 0; m_halted = 1; end
            end else if (m_step == 1) begin
                m_step = 2;
            end else if (f_at) begin
                m_step = 0; m_halted = 1;
            end
        end
    end

    task automatic send(input logic [1:0] op);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_halted(input int max, input string nm);
        int n = 0;
        while (!bus.halted && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 32'(bus.halted), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [31:0] pc_rec;
    int          n;

    initial begin
        reset = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
        bus.bp_enable = 1'b0; bus.bp_addr = 32'h0;
        do_reset();
        chk("init_ready", 32'(bus.cmd_ready), 1);

        // Single step of the 4-cycle instruction at PC 0
        send(2'b10);
        wait_halted(20, "step_timeout");
        chk("step_icnt", 32'(bus.instr_count), 1);
        chk("step_ccnt", 32'(bus.cycle_count), 4);
        chk("step_pc", bus.fetchPC, 32'h4);

        // Breakpoint at 0x10: 4+5+3+4 = 16 enabled cycles wrap to 0
        do_reset();
        bus.bp_enable = 1'b1; bus.bp_addr = 32'h10;
        send(2'b01);
        wait_halted(100, "bp_timeout");
        chk("bp_pc", bus.fetchPC, 32'h10);
        chk("bp_hit_set", 32'(bus.bp_hit), 1);
        chk("bp_enable_low", 32'(bus.cpu_enable), 0);
        chk("bp_icnt", 32'(bus.instr_count), 4);
        chk("bp_ccnt_wrap", 32'(bus.cycle_count), 0);
        chk("model_icnt", 32'(m_icnt), 4);

        // Resume over the breakpoint: 0x10 runs (5 cycles), no re-halt
        send(2'b01);
        chk("resume_hit_clr", 32'(bus.bp_hit), 0);
        n = 0;
        while (!(bus.fetchPC == 32'h14 && bus.fsm_state == 4'd0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("resume_reach", 32'(n < 50), 1);
        chk("resume_running", 32'(bus.halted), 0);
        chk("resume_icnt", 32'(bus.instr_count), 5);
        chk("resume_ccnt", 32'(bus.cycle_count), 5);

        // HALT mid-instruction drains to the next fetch
        n = 0;
        while (bus.fsm_state != 4'd2 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        pc_rec = bus.fetchPC;
        send(2'b00);
        wait_halted(20, "drain_timeout");
        chk("drain_fsm", 32'(bus.fsm_state), 0);
        chk("drain_pc", bus.fetchPC, pc_rec);

        // HALT coinciding with a breakpoint match
        bus.bp_addr = 32'h20;
        send(2'b01);
        n = 0;
        while (!(bus.fetchPC == 32'h20 && bus.fsm_state == 4'd0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        send(2'b00);
        chk("bp_halt_halted", 32'(bus.halted), 1);
        chk("bp_halt_hit", 32'(bus.bp_hit), 1);
        chk("bp_halt_pc", bus.fetchPC, 32'h20);

        // Asynchronous reset in the middle of a step
        bus.bp_enable = 1'b0;
        send(2'b10);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("arst_halted", 32'(bus.halted), 1);
        chk("arst_icnt", 32'(bus.instr_count), 0);
        chk("arst_ccnt", 32'(bus.cycle_count), 0);
        chk("arst_hit", 32'(bus.bp_hit), 0);
        @(negedge clk); #2;
        reset = 1'b1;

        // Randomized command / breakpoint traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.cmd_valid = ($urandom_range(0, 5) == 0);
            bus.cmd_op    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                bus.bp_enable = 1'($urandom_range(0, 1));
                bus.bp_addr   = bus.fetchPC + 32'(4 * $urandom_range(0, 3));
            end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
